line_clear_sequencer: RTL and testbench

Sequences the board-row memory during a line clear: given the completed-lines mask from the game controller, it compacts surviving rows toward the bottom of the board and zero-fills the vacated rows at the top. It also reports how many lines were cleared and the matching score increment. It sits between the main game FSM, which issues start and waits for done in its clear-line state, and the single-port-per-direction board row RAM.

---
 rtl/tetris_pkg.sv | 23 ++
 rtl/clear_score_lut.sv | 21 ++
 rtl/line_clear_sequencer.sv | 148 ++++++++++++++
 tb/tb_line_clear_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, score table and sequencer state encoding for the
// Tetris datapath blocks.
package tetris_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int CNT_W   = 5;
  localparam int SCORE_W = 11;

  localparam logic [SCORE_W-1:0] SCORE_1 = 11'd40;
  localparam logic [SCORE_W-1:0] SCORE_2 = 11'd100;
  localparam logic [SCORE_W-1:0] SCORE_3 = 11'd300;
  localparam logic [SCORE_W-1:0] SCORE_4 = 11'd1200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WRITE,
    ST_FILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/clear_score_lut.sv
// Maps a cleared-line count to its score increment; four or more lines
// saturate at the tetris award. Also used by the score display.
module clear_score_lut
  import tetris_pkg::*;
(
  input  logic [CNT_W-1:0]   count_i,
  output logic [SCORE_W-1:0] score_delta_o
);

  always_comb begin
    score_delta_o = SCORE_4;
    case (count_i)
      CNT_W'(0): score_delta_o = '0;
      CNT_W'(1): score_delta_o = SCORE_1;
      CNT_W'(2): score_delta_o = SCORE_2;
      CNT_W'(3): score_delta_o = SCORE_3;
      default:   score_delta_o = SCORE_4;
    endcase
  end

endmodule

// File: rtl/line_clear_sequencer.sv
// Line-clear sequencer: compacts surviving board rows toward the bottom,
// zero-fills the vacated top rows, and reports lines cleared and score.
module line_clear_sequencer #(
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int COLS = tetris_pkg::COLS,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic                               start,
  input  logic [ROWS-1:0]                    completed_lines,
  output logic                               busy,
  output logic                               done,
  output logic [tetris_pkg::CNT_W-1:0]       lines_cleared,
  output logic [tetris_pkg::SCORE_W-1:0]     score_delta,
  output logic [RW-1:0]                      rd_addr,
  input  logic [COLS-1:0]                    rd_data,
  output logic                               wr_en,
  output logic [RW-1:0]                      wr_addr,
  output logic [COLS-1:0]                    wr_data
);
  import tetris_pkg::*;

  state_e             state_q;
  logic [ROWS-1:0]    mask_q;
  logic [RW-1:0]      src_q;
  logic [RW-1:0]      dst_q;
  logic               src_uf_q;
  logic               dst_uf_q;
  logic [CNT_W-1:0]   count_q;
  logic               busy_q;
  logic               done_q;
  logic               wr_en_q;
  logic [RW-1:0]      wr_addr_q;
  logic [COLS-1:0]    wr_data_q;
  logic [CNT_W-1:0]   lines_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_lut;
  logic [RW:0]        src_dec_d;
  logic [RW:0]        dst_dec_d;

  // Decrement a row pointer; stepping below row 0 raises the underflow bit.
  function automatic logic [RW:0] dec_ptr(input logic [RW-1:0] p);
    if (p == '0) return {1'b1, {RW{1'b0}}};
    return {1'b0, p - RW'(1)};
  endfunction

  assign src_dec_d = dec_ptr(src_q);
  assign dst_dec_d = dec_ptr(dst_q);

  clear_score_lut u_score_lut (
    .count_i       (count_q),
    .score_delta_o (score_lut)
  );

  // The read is issued from SCAN so the row is on rd_data during WRITE.
  assign rd_addr       = (state_q == ST_SCAN) ? src_q : '0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign lines_cleared = lines_q;
  assign score_delta   = score_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      lines_q   <= '0;
      score_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_q   <= completed_lines;
            src_q    <= RW'(ROWS - 1);
            dst_q    <= RW'(ROWS - 1);
            src_uf_q <= 1'b0;
            dst_uf_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            if (completed_lines == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              lines_q <= '0;
              score_q <= '0;
            end else begin
              state_q <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (src_uf_q) begin
            if (!dst_uf_q) begin
              state_q <= ST_FILL;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              lines_q <= count_q;
              score_q <= score_lut;
            end
          end else if (mask_q[src_q]) begin
            count_q             <= count_q + CNT_W'(1);
            {src_uf_q, src_q}   <= src_dec_d;
          end else if (src_q == dst_q) begin
            {src_uf_q, src_q}   <= src_dec_d;
            {dst_uf_q, dst_q}   <= dst_dec_d;
          end else begin
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr_en_q           <= 1'b1;
          wr_addr_q         <= dst_q;
          wr_data_q         <= rd_data;
          {src_uf_q, src_q} <= src_dec_d;
          {dst_uf_q, dst_q} <= dst_dec_d;
          state_q           <= ST_SCAN;
        end
        ST_FILL: begin
          wr_en_q           <= 1'b1;
          wr_addr_q         <= dst_q;
          wr_data_q         <= '0;
          {dst_uf_q, dst_q} <= dst_dec_d;
          if (dst_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            lines_q <= count_q;
            score_q <= score_lut;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Scoreboard bench for line_clear_sequencer with a behavioural board RAM.
module tb_line_clear_sequencer;

  localparam int R  = 20;
  localparam int C  = 10;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [R-1:0]  completed_lines = '0;
  logic          busy, done, wr_en;
  logic [4:0]    lines_cleared;
  logic [10:0]   score_delta;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [C-1:0]  rd_data, wr_data;

  line_clear_sequencer #(.ROWS(R), .COLS(C), .RW(AW)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .completed_lines (completed_lines),
    .busy            (busy),
    .done            (done),
    .lines_cleared   (lines_cleared),
    .score_delta     (score_delta),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data)
  );

  always #5 clock = ~clock;

  logic [C-1:0]  mem [R];
  logic [C-1:0]  ref_mem [R];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [C-1:0]  ld_data = '0;

  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed { logic [AW-1:0] addr; logic [C-1:0] data; } wr_t;
  typedef struct packed { logic [31:0] cyc; logic [4:0] cnt; logic [10:0] sc; } res_t;
  wr_t  wq[$];
  res_t rq[$];
  wr_t  ew;
  res_t er;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int t0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] exp_score(input int n);
    case (n)
      0: return 11'd0;
      1: return 11'd40;
      2: return 11'd100;
      3: return 11'd300;
      default: return 11'd1200;
    endcase
  endfunction

  always @(negedge clock) begin
    if (wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        ew = wq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(ew.addr));
        chk("wr_data", 32'(wr_data), 32'(ew.data));
      end
    end
    if (done) begin
      n_done++;
      if (rq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        er = rq.pop_front();
        chk("done_cycle", 32'(cyc - t0), er.cyc);
        chk("lines_cleared", 32'(lines_cleared), 32'(er.cnt));
        chk("score_delta", 32'(score_delta), 32'(er.sc));
        chk("busy_in_done", 32'(busy), 1);
      end
    end
  end

  // Reference compaction: k-th surviving row from the bottom lands at R-1-k.
  task automatic plan_pass(input logic [R-1:0] m);
    logic [C-1:0] nxt [R];
    int k, ncopy, cnt;
    wr_t w;
    res_t r;
    k = 0; ncopy = 0; cnt = 0;
    for (int i = 0; i < R; i++) nxt[i] = '0;
    for (int s = R - 1; s >= 0; s--) begin
      if (m[s]) cnt++;
      else begin
        nxt[R-1-k] = ref_mem[s];
        if (R - 1 - k != s) begin
          w.addr = AW'(R - 1 - k);
          w.data = ref_mem[s];
          wq.push_back(w);
          ncopy++;
        end
        k++;
      end
    end
    for (int d = R - 1 - k; d >= 0; d--) begin
      w.addr = AW'(d);
      w.data = '0;
      wq.push_back(w);
    end
    ref_mem = nxt;
    r.cnt = 5'(cnt);
    r.sc  = exp_score(cnt);
    r.cyc = (m == '0) ? 32'd1 : 32'(1 + R + ncopy + 1 + (R - k));
    rq.push_back(r);
  endtask

  task automatic preload(input int seed);
    for (int i = 0; i < R; i++) begin
      @(negedge clock);
      ld_en = 1'b1;
      ld_addr = AW'(i);
      ld_data = C'((i + 1) * 41 + seed);
      ref_mem[i] = C'((i + 1) * 41 + seed);
    end
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic do_start(input logic [R-1:0] m, input bit plan);
    @(negedge clock);
    completed_lines = m;
    start = 1'b1;
    t0 = cyc;
    if (plan) plan_pass(m);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (rq.size() != 0) begin
      chk("done_timeout", 32'(rq.size()), 0);
      rq.delete();
    end
    repeat (2) @(negedge clock);
    chk("writes_pending", 32'(wq.size()), 0);
    wq.delete();
    chk("busy_idle", 32'(busy), 0);
    for (int i = 0; i < R; i++) chk($sformatf("mem_row%0d", i), 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  task automatic run_pass(input logic [R-1:0] m);
    do_start(m, 1'b1);
    wait_done();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_wr_en"}, 32'(wr_en), 0);
    chk({pfx, "_rd_addr"}, 32'(rd_addr), 0);
    chk({pfx, "_wr_addr"}, 32'(wr_addr), 0);
    chk({pfx, "_wr_data"}, 32'(wr_data), 0);
    chk({pfx, "_lines"}, 32'(lines_cleared), 0);
    chk({pfx, "_score"}, 32'(score_delta), 0);
  endtask

  initial begin
    int d0;
    logic [R-1:0] hm;
    repeat (3) @(negedge clock);
    chk_reset_outputs("rst");
    resetn = 1'b1;

    preload(0);
    run_pass(20'h00000);
    run_pass(20'h80000);
    preload(3);
    run_pass(20'hF0000);
    preload(7);
    run_pass(20'h00420);

    // start held through the pass while completed_lines wanders
    preload(11);
    hm = 20'h01088;
    d0 = n_done;
    @(negedge clock);
    completed_lines = hm;
    start = 1'b1;
    t0 = cyc;
    plan_pass(hm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (i == 5) completed_lines = ~hm;
      if (i == 20) completed_lines = 20'hFFFFF;
      if (done) break;
    end
    start = 1'b0;
    completed_lines = '0;
    wait_done();
    repeat (4) @(negedge clock);
    chk("single_done", 32'(n_done - d0), 1);

    // reset while the first copy of row 9 is in WRITE
    preload(13);
    do_start(20'h00400, 1'b0);
    while (cyc < t0 + 12) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk_reset_outputs("midrst");
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    for (int i = 0; i < R; i++) chk($sformatf("midrst_row%0d", i), 32'(mem[i]), 32'(ref_mem[i]));
    run_pass(20'h00420);

    run_pass(20'h005A5);
    run_pass(20'hFFFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
